// File: rtl/lcd_pkg.sv
// Shared constants and state types for the product LCD writer: HD44780 command
// bytes, the ASCII glyphs used by the "P=ddddd" line, and the FSM enums.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] LINE1    = 8'h80;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    localparam logic [2:0] INIT_LAST  = 3'd5;
    localparam logic [2:0] WRITE_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_INIT     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_CONVERT  = 3'd3,
        ST_WRITE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EHIGH = 2'd1,
        PH_HOLD  = 2'd2,
        PH_WAIT  = 2'd3
    } phase_e;

    // Power-up command list, three function-sets first as the controller requires.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0, 3'd1, 3'd2: b = FUNC_SET;
            3'd3:             b = DISP_ON;
            3'd4:             b = CLEAR;
            3'd5:             b = ENTRY;
            default:          b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to five BCD digits in 17 cycles
// (one load cycle plus 16 add-3/shift cycles); done pulses with the result.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    logic [35:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    function automatic logic [35:0] add3(input logic [35:0] s);
        logic [35:0] r;
        r = s;
        for (int k = 0; k < 5; k++) begin
            if (r[16 + 4*k +: 4] >= 4'd5) begin
                r[16 + 4*k +: 4] = r[16 + 4*k +: 4] + 4'd3;
            end else begin
                r[16 + 4*k +: 4] = r[16 + 4*k +: 4];
            end
        end
        return r;
    endfunction

    // Load, then correct-and-shift once per cycle until the count runs out.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            sh_d  = {20'd0, bin};
            cnt_d = 5'd16;
        end else if (cnt_q != 5'd0) begin
            sh_d   = add3(sh_q) << 1;
            cnt_d  = cnt_q - 5'd1;
            done_d = (cnt_q == 5'd1);
        end else begin
            sh_d = sh_q;
        end
    end

    // Conversion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= 36'd0;
            cnt_q  <= 5'd0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = sh_q[35:16];

endmodule

// File: rtl/product_lcd_writer.sv
// Drives an HD44780 LCD in 8-bit mode: power-up init, then "P=ddddd" on line 1
// for every new product, with one pending slot for strobes arriving while busy.
module product_lcd_writer
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_CYC = 1_000_000,
    parameter int unsigned CMD_CYC = 2_500,
    parameter int unsigned CLR_CYC = 100_000,
    parameter int unsigned E_CYC   = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] product,
    input  logic        product_valid,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data
);

    localparam int unsigned MAX_A = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int unsigned MAX_B = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam int unsigned MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          CW    = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          pend_q, pend_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic          start_q, start_d;
    logic [15:0]   bin_q, bin_d;
    logic          lcd_e_q, lcd_e_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          busy_q, busy_d;

    logic          done_s;
    logic [19:0]   bcd_s;
    logic [2:0]    last_idx_s;
    logic [8:0]    next_byte_s;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_q),
        .bin   (bin_q),
        .done  (done_s),
        .bcd   (bcd_s)
    );

    // {rs, data} for slot idx of the init list or of the "P=ddddd" line.
    function automatic logic [8:0] slot_byte(input logic is_init, input logic [2:0] idx,
                                             input logic [19:0] bcd);
        logic [8:0] b;
        if (is_init) begin
            b = {1'b0, init_byte(idx)};
        end else begin
            case (idx)
                3'd0:    b = {1'b0, LINE1};
                3'd1:    b = {1'b1, ASCII_P};
                3'd2:    b = {1'b1, ASCII_EQ};
                3'd3:    b = {1'b1, ASCII_0 + {4'd0, bcd[19:16]}};
                3'd4:    b = {1'b1, ASCII_0 + {4'd0, bcd[15:12]}};
                3'd5:    b = {1'b1, ASCII_0 + {4'd0, bcd[11:8]}};
                3'd6:    b = {1'b1, ASCII_0 + {4'd0, bcd[7:4]}};
                3'd7:    b = {1'b1, ASCII_0 + {4'd0, bcd[3:0]}};
                default: b = 9'h000;
            endcase
        end
        return b;
    endfunction

    // Pending slot: strobes outside IDLE are remembered (latest wins); IDLE consumes it.
    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (product_valid) begin
            pend_val_d = product;
            pend_d     = (state_q != ST_IDLE) || pend_q;
        end else if (state_q == ST_IDLE) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Top FSM and byte-write slot sequencer.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        start_d     = 1'b0;
        bin_d       = bin_q;
        lcd_e_d     = lcd_e_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        last_idx_s  = (state_q == ST_INIT) ? INIT_LAST : WRITE_LAST;
        next_byte_s = slot_byte(state_q == ST_INIT, idx_q + 3'd1, bcd_s);
        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_INIT;
                    idx_d   = 3'd0;
                    phase_d = PH_SETUP;
                    {lcd_rs_d, lcd_data_d} = slot_byte(1'b1, 3'd0, bcd_s);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (pend_q) begin
                    bin_d   = pend_val_q;
                    start_d = 1'b1;
                    state_d = ST_CONVERT;
                end else if (product_valid) begin
                    bin_d   = product;
                    start_d = 1'b1;
                    state_d = ST_CONVERT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (done_s) begin
                    state_d = ST_WRITE;
                    idx_d   = 3'd0;
                    phase_d = PH_SETUP;
                    {lcd_rs_d, lcd_data_d} = slot_byte(1'b0, 3'd0, bcd_s);
                end else begin
                    state_d = ST_CONVERT;
                end
            end
            ST_INIT, ST_WRITE: begin
                case (phase_q)
                    PH_SETUP: begin
                        lcd_e_d = 1'b1;
                        cnt_d   = CW'(E_CYC - 1);
                        phase_d = PH_EHIGH;
                    end
                    PH_EHIGH: begin
                        if (cnt_q == CNT_ZERO) begin
                            lcd_e_d = 1'b0;
                            phase_d = PH_HOLD;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    PH_HOLD: begin
                        phase_d = PH_WAIT;
                        // Only the clear command needs the long execution wait.
                        if (!lcd_rs_q && (lcd_data_q == CLEAR)) begin
                            cnt_d = CW'(CLR_CYC - 1);
                        end else begin
                            cnt_d = CW'(CMD_CYC - 1);
                        end
                    end
                    PH_WAIT: begin
                        if (cnt_q != CNT_ZERO) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else if (idx_q == last_idx_s) begin
                            state_d = ST_IDLE;
                            idx_d   = 3'd0;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            phase_d = PH_SETUP;
                            {lcd_rs_d, lcd_data_d} = next_byte_s;
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end
            default: state_d = ST_PWR_WAIT;
        endcase
        busy_d = (state_d != ST_IDLE) || pend_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PWR_WAIT;
            phase_q    <= PH_SETUP;
            cnt_q      <= CW'(PWR_CYC - 1);
            idx_q      <= 3'd0;
            pend_q     <= 1'b0;
            pend_val_q <= 16'd0;
            start_q    <= 1'b0;
            bin_q      <= 16'd0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            start_q    <= start_d;
            bin_q      <= bin_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = lcd_e_q;
    assign lcd_data = lcd_data_q;

endmodule
